// File: rtl/wave_gen_param.sv
// Programmable square/PWM wave generator with free-run and one-shot modes.
// Period and high time arrive through a valid/ready port into shadow
// registers and are applied only at period starts (or straight away while
// idle), so a period that has already begun is never altered.
module wave_gen_param #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             trig,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             q,
  output logic             qbar,
  output logic             y,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d, high_sh_q, high_sh_d;
  logic [CNT_W-1:0] per_a_q, per_a_d, high_a_q, high_a_d;
  logic             pend_q, pend_d;
  logic             mode_a_q, mode_a_d;
  logic             ready_q, ready_d;
  logic             q_q, q_d, qbar_q, qbar_d, y_q, y_d, busy_q, busy_d;
  logic             start, xfer;
  logic [CNT_W-1:0] per_clamp, high_clamp, low_last;

  // Clamp the requested config into a legal period/high pair.
  always_comb begin
    per_clamp  = (cfg_period < TWO) ? TWO : cfg_period;
    high_clamp = (cfg_high == '0) ? ONE : cfg_high;
    if (high_clamp >= per_clamp) high_clamp = per_clamp - ONE;
  end

  // Last count of the low phase; period_a > high_a so this never wraps.
  assign low_last = per_a_q - high_a_q - ONE;
  assign xfer     = cfg_valid && ready_q;

  // Next-state, counter, config shadowing and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE;
    start     = 1'b0;
    mode_a_d  = mode_a_q;
    per_sh_d  = per_sh_q;
    high_sh_d = high_sh_q;
    per_a_d   = per_a_q;
    high_a_d  = high_a_q;
    pend_d    = pend_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && (!mode || trig)) start = 1'b1;
      end
      HIGH: begin
        if (cnt_q == high_a_q - ONE) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (cnt_q == low_last) begin
          cnt_d = '0;
          if (!mode_a_q && en) start = 1'b1;
          else state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      state_d  = HIGH;
      cnt_d    = '0;
      mode_a_d = mode;
    end

    // Pending shadow goes live only while idle or exactly at a period start.
    if (pend_q && (state_q == IDLE || start)) begin
      per_a_d  = per_sh_q;
      high_a_d = high_sh_q;
      pend_d   = 1'b0;
    end

    // A capture on the same edge as a start lands in the shadow for next time.
    if (xfer) begin
      per_sh_d  = per_clamp;
      high_sh_d = high_clamp;
      pend_d    = 1'b1;
    end

    ready_d = !xfer;
    q_d     = (state_d == HIGH);
    qbar_d  = !q_d;
    busy_d  = (state_d != IDLE);
    y_d     = start;
  end

  // State, config and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_sh_q  <= DEF_P;
      high_sh_q <= DEF_H;
      per_a_q   <= DEF_P;
      high_a_q  <= DEF_H;
      pend_q    <= 1'b0;
      mode_a_q  <= 1'b0;
      ready_q   <= 1'b1;
      q_q       <= 1'b0;
      qbar_q    <= 1'b1;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      high_sh_q <= high_sh_d;
      per_a_q   <= per_a_d;
      high_a_q  <= high_a_d;
      pend_q    <= pend_d;
      mode_a_q  <= mode_a_d;
      ready_q   <= ready_d;
      q_q       <= q_d;
      qbar_q    <= qbar_d;
      y_q       <= y_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_ready = ready_q;
  assign q         = q_q;
  assign qbar      = qbar_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wave_gen_param.sv
// Bench for wave_gen_param: directed scenarios followed by random traffic,
// every cycle compared against a position-within-period reference model.
module tb_wave_gen_param;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, mode, trig, cfg_valid;
  logic [CNT_W-1:0] cfg_period, cfg_high;
  logic             cfg_ready, q, qbar, y, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a period is "busy" with position pos in 0..per-1,
  // and the wave is high while pos < hi.
  bit m_busy, m_pend, m_ready, m_mode_a, m_y;
  int m_pos, m_per, m_hi, m_sh_per, m_sh_hi;

  wave_gen_param #(.CNT_W(CNT_W), .DEF_PERIOD(4), .DEF_HIGH(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig(trig),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .q(q), .qbar(qbar), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit start, xfer;
    int p, h;
    if (rst) begin
      m_busy = 0; m_pos = 0; m_per = 4; m_hi = 2; m_sh_per = 4; m_sh_hi = 2;
      m_pend = 0; m_ready = 1; m_mode_a = 0; m_y = 0;
      return;
    end
    xfer  = cfg_valid && m_ready;
    start = 0;
    if (!m_busy) start = en && (!mode || trig);
    else if (m_pos == m_per - 1) start = !m_mode_a && en;
    if (m_pend && (!m_busy || start)) begin
      m_per = m_sh_per; m_hi = m_sh_hi; m_pend = 0;
    end
    if (xfer) begin
      p = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
      h = (cfg_high == 0) ? 1 : int'(cfg_high);
      if (h >= p) h = p - 1;
      m_sh_per = p; m_sh_hi = h; m_pend = 1;
    end
    m_ready = !xfer;
    if (start) begin
      m_busy = 1; m_pos = 0; m_mode_a = mode;
    end else if (m_busy) begin
      if (m_pos == m_per - 1) m_busy = 0;
      else m_pos++;
    end
    m_y = start;
  endtask

  task automatic step();
    bit exp_q;
    @(posedge clk);
    model_edge();
    #1;
    exp_q = m_busy && (m_pos < m_hi);
    check_val("q", q, exp_q);
    check_val("qbar", qbar, !exp_q);
    check_val("y", y, m_y);
    check_val("busy", busy, m_busy);
    check_val("cfg_ready", cfg_ready, m_ready);
    $display("t=%0t rst=%0b en=%0b mode=%0b trig=%0b cv=%0b cp=%0d ch=%0d -> q=%0b y=%0b busy=%0b rdy=%0b",
             $time, rst, en, mode, trig, cfg_valid, cfg_period, cfg_high,
             q, y, busy, cfg_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_pulse(input int p, input int h);
    cfg_valid = 1; cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
    step();
    cfg_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && m_busy; i++) step();
    check_val("wait_idle", busy, 0);
  endtask

  task automatic wait_period_start();
    for (int i = 0; i < 600 && !(m_busy && m_pos == 0); i++) step();
    check_val("wait_start", busy, 1);
  endtask

  initial begin
    rst = 1; en = 0; mode = 0; trig = 0; cfg_valid = 0;
    cfg_period = '0; cfg_high = '0;
    run(2);
    check_val("rst_q", q, 0);
    check_val("rst_qbar", qbar, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", cfg_ready, 1);
    rst = 0;

    // Free run with defaults.
    en = 1; run(12);
    // Reconfigure to 5/1 during the first cycle of a high phase.
    wait_period_start();
    cfg_pulse(5, 1);
    run(14);
    // Clamp while idle, then free run at period 2 / high 1.
    en = 0; wait_idle();
    cfg_pulse(0, 9);
    run(1);
    en = 1; run(10);
    // One-shot with a second trig inside the busy window.
    en = 0; wait_idle();
    cfg_pulse(4, 2);
    run(1);
    mode = 1; en = 1; trig = 1; step();
    trig = 0; step();
    trig = 1; step();
    trig = 0; run(6);
    // Drop en in the first cycle of a free-run period.
    mode = 0; en = 1; step();
    en = 0; run(8);
    // Long period, then reset mid-high.
    cfg_pulse(200, 100);
    en = 1; run(3);
    wait_period_start();
    run(40);
    rst = 1; step();
    check_val("midrst_q", q, 0);
    check_val("midrst_qbar", qbar, 1);
    check_val("midrst_y", y, 0);
    check_val("midrst_busy", busy, 0);
    rst = 0; run(10);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 7) != 0);
      mode      = ($urandom_range(0, 3) == 0);
      trig      = ($urandom_range(0, 3) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 15);
      if (r == 0) cfg_period = 8'd255;
      else if (r == 1) cfg_period = CNT_W'($urandom_range(0, 255));
      else cfg_period = CNT_W'($urandom_range(0, 10));
      cfg_high = (r == 0) ? CNT_W'($urandom_range(0, 255))
                          : CNT_W'($urandom_range(0, 12));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
